// File: rtl/debounce_bank.sv
// Multi-channel switch debouncer: one shared sample prescaler and one shared
// stability-update datapath, serviced round-robin across channels on each tick.
module debounce_bank #(
    parameter int NUM_SW     = 4,
    parameter int TICK_DIV   = 500_000,
    parameter int STABLE_CNT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_SW-1:0] sw_i,
    output logic [NUM_SW-1:0] db_level_o,
    output logic [NUM_SW-1:0] db_rise_o,
    output logic [NUM_SW-1:0] db_fall_o,
    output logic              scan_busy_o
);
    localparam int CW = $clog2(TICK_DIV);
    localparam int NW = $clog2(STABLE_CNT + 1);
    localparam int PW = (NUM_SW > 1) ? $clog2(NUM_SW) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [NW-1:0] CNT_LAST  = NW'(STABLE_CNT - 1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(NUM_SW - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                    state;
    logic [NUM_SW-1:0]         sync_p0;
    logic [NUM_SW-1:0]         sync_p1;
    logic [CW-1:0]             prescale;
    logic                      sample_tick;
    logic [PW-1:0]             ptr;
    logic [NUM_SW-1:0][NW-1:0] cnt;

    logic          cur_sync;
    logic          cur_level;
    logic [NW-1:0] cur_cnt;
    logic          differ;
    logic          accept;

    // A matching sample clears the run; a differing one extends it, wrapping to 0 on acceptance.
    function automatic logic [NW-1:0] next_cnt(input logic diff, input logic [NW-1:0] c);
        if (!diff || c == CNT_LAST)
            return '0;
        return c + NW'(1);
    endfunction

    assign sample_tick = (prescale == TICK_LAST);

    always_comb begin
        cur_sync  = sync_p1[ptr];
        cur_level = db_level_o[ptr];
        cur_cnt   = cnt[ptr];
        differ    = cur_sync ^ cur_level;
        accept    = differ && (cur_cnt == CNT_LAST);
    end

    // Input synchronizers and sample prescaler
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_p0  <= '0;
            sync_p1  <= '0;
            prescale <= '0;
        end else begin
            sync_p0  <= sw_i;
            sync_p1  <= sync_p0;
            prescale <= sample_tick ? '0 : prescale + CW'(1);
        end
    end

    // Scan controller and shared channel service
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            ptr         <= '0;
            scan_busy_o <= 1'b0;
            db_level_o  <= '0;
            db_rise_o   <= '0;
            db_fall_o   <= '0;
            cnt         <= '0;
        end else begin
            db_rise_o <= '0;
            db_fall_o <= '0;
            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        state       <= SCAN;
                        scan_busy_o <= 1'b1;
                        ptr         <= '0;
                    end
                end
                SCAN: begin
                    cnt[ptr] <= next_cnt(differ, cur_cnt);
                    if (accept) begin
                        db_level_o[ptr] <= cur_sync;
                        db_rise_o[ptr]  <= cur_sync;
                        db_fall_o[ptr]  <= ~cur_sync;
                    end
                    if (ptr == PTR_LAST) begin
                        state       <= IDLE;
                        scan_busy_o <= 1'b0;
                        ptr         <= '0;
                    end else begin
                        ptr <= ptr + PW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
